// File: rtl/t_ff_pkg.sv
// Shared constants and the COUNT-mode toggle chain for the T flip-flop array.
// Optional feature macro used by the array: T_FF_LOAD_EN.
package t_ff_pkg;

  localparam logic MODE_INDEP = 1'b0;
  localparam logic MODE_COUNT = 1'b1;
  localparam int   MAX_WIDTH  = 32;

  // T[0] is always 1; each higher bit toggles when every lower bit sits at the carry/borrow value.
  function automatic logic [MAX_WIDTH-1:0] toggle_vec(input logic [MAX_WIDTH-1:0] q,
                                                      input logic                 up);
    logic [MAX_WIDTH-1:0] tv;
    tv    = '0;
    tv[0] = 1'b1;
    for (int i = 1; i < MAX_WIDTH; i++) begin
      tv[i] = tv[i-1] & (up ? q[i-1] : ~q[i-1]);
    end
    return tv;
  endfunction

endpackage

// File: rtl/t_ff_cell.sv
// One clocked T flip-flop with synchronous reset and a load that outranks the enable.
// Priority on each rising edge: rst > ld > (en & t) toggle > hold. Output is the registered state.
module t_ff_cell (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic t,
  input  logic ld,
  input  logic d,
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = d;
    end else if (en && t) begin
      q_d = ~q_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/t_flip_flop_array.sv
// WIDTH T flip-flops: per-bit toggling (mode=0) or a chained up/down counter with terminal count (mode=1).
// Edge-triggered, one cycle to q; macro T_FF_LOAD_EN adds the load/d parallel-load ports.
module t_flip_flop_array
  import t_ff_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             up,
  input  logic [WIDTH-1:0] t,
`ifdef T_FF_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] d,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             tc
);

  logic                 ld_sel;
  logic [WIDTH-1:0]     ld_dat;
  logic [MAX_WIDTH-1:0] q_ext;
  logic [MAX_WIDTH-1:0] chain_t;
  logic [WIDTH-1:0]     t_vec;

`ifdef T_FF_LOAD_EN
  assign ld_sel = load;
  assign ld_dat = d;
`else
  assign ld_sel = 1'b0;
  assign ld_dat = '0;
`endif

  // Upper bits of the extended word never influence the low WIDTH toggle bits.
  always_comb begin
    q_ext             = '0;
    q_ext[WIDTH-1:0]  = q;
    chain_t           = toggle_vec(q_ext, up);
    t_vec             = (mode == MODE_COUNT) ? chain_t[WIDTH-1:0] : t;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    t_ff_cell u_cell (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .t   (t_vec[i]),
      .ld  (ld_sel),
      .d   (ld_dat[i]),
      .q   (q[i])
    );
  end

  assign q_bar = ~q;
  assign tc    = en & (mode == MODE_COUNT) & (up ? (&q) : ~(|q));

endmodule

// File: tb/tb_t_flip_flop_array.sv
// Directed self-checking bench for t_flip_flop_array (WIDTH=4); load tests only when T_FF_LOAD_EN is defined.
module tb_t_flip_flop_array;

  logic       clk;
  logic       rst;
  logic       en;
  logic       mode;
  logic       up;
  logic [3:0] t;
  logic [3:0] q;
  logic [3:0] q_bar;
  logic       tc;
`ifdef T_FF_LOAD_EN
  logic       load;
  logic [3:0] d;
`endif

  int checks   = 0;
  int failures = 0;

  t_flip_flop_array #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .mode  (mode),
    .up    (up),
    .t     (t),
`ifdef T_FF_LOAD_EN
    .load  (load),
    .d     (d),
`endif
    .q     (q),
    .q_bar (q_bar),
    .tc    (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; mode = 1'b0; up = 1'b1; t = 4'hF;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (q !== 4'h0 || q_bar !== 4'hF || tc !== 1'b0) begin
        failures++;
        $display("FAIL reset[%0d]: q=%h q_bar=%h tc=%b expected q=0 q_bar=F tc=0", i, q, q_bar, tc);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_indep();
    logic [3:0] exp_q [3];
    exp_q[0] = 4'h5; exp_q[1] = 4'h0; exp_q[2] = 4'h5;
    en = 1'b1; mode = 1'b0; t = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (q !== exp_q[i] || q_bar !== ~exp_q[i] || tc !== 1'b0) begin
        failures++;
        $display("FAIL indep[%0d]: q=%h q_bar=%h tc=%b expected q=%h q_bar=%h tc=0",
                 i, q, q_bar, tc, exp_q[i], ~exp_q[i]);
      end
    end
    // Disabled: hold regardless of t, mode and up; tc forced low.
    en = 1'b0; t = 4'hF; mode = 1'b1; up = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (q !== 4'h5 || tc !== 1'b0) begin
        failures++;
        $display("FAIL indep_hold[%0d]: q=%h tc=%b expected q=5 tc=0", i, q, tc);
      end
    end
    en = 1'b1; mode = 1'b0; t = 4'hF;
    tick();
    checks++;
    if (q !== 4'hA) begin
      failures++;
      $display("FAIL indep_complement: q=%h expected A", q);
    end
    t = 4'h0;
    tick();
    checks++;
    if (q !== 4'hA) begin
      failures++;
      $display("FAIL indep_t_zero: q=%h expected A", q);
    end
  endtask

  task automatic test_count_up();
    logic [3:0] exp_q;
    rst = 1'b1;
    tick();
    rst = 1'b0; en = 1'b1; mode = 1'b1; up = 1'b1; t = 4'h0;
    exp_q = 4'h0;
    for (int i = 0; i < 17; i++) begin
      tick();
      exp_q = exp_q + 4'h1;
      checks++;
      if (q !== exp_q || tc !== (exp_q == 4'hF)) begin
        failures++;
        $display("FAIL count_up[%0d]: q=%h tc=%b expected q=%h tc=%b",
                 i, q, tc, exp_q, (exp_q == 4'hF));
      end
    end
  endtask

  task automatic test_count_down();
    logic [3:0] exp_q;
    rst = 1'b1;
    tick();
    rst = 1'b0; en = 1'b1; mode = 1'b1; up = 1'b0;
    #1;
    checks++;
    if (tc !== 1'b1) begin
      failures++;
      $display("FAIL count_down_tc_at_zero: tc=%b expected 1", tc);
    end
    exp_q = 4'h0;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_q = exp_q - 4'h1;
      checks++;
      if (q !== exp_q || tc !== 1'b0) begin
        failures++;
        $display("FAIL count_down[%0d]: q=%h tc=%b expected q=%h tc=0", i, q, tc, exp_q);
      end
    end
    up = 1'b1;
    tick();
    checks++;
    if (q !== 4'hB) begin
      failures++;
      $display("FAIL count_dir_flip: q=%h expected B", q);
    end
    // Switching to INDEP keeps the count value and forces tc low.
    mode = 1'b0; t = 4'h0;
    #1;
    checks++;
    if (tc !== 1'b0 || q !== 4'hB) begin
      failures++;
      $display("FAIL mode_switch: q=%h tc=%b expected q=B tc=0", q, tc);
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    tick();
    rst = 1'b0; en = 1'b1; mode = 1'b1; up = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (q !== 4'h7) begin
      failures++;
      $display("FAIL reset_mid_pre: q=%h expected 7", q);
    end
    rst = 1'b1;
`ifdef T_FF_LOAD_EN
    load = 1'b1; d = 4'h3;
`endif
    tick();
    checks++;
    if (q !== 4'h0 || q_bar !== 4'hF) begin
      failures++;
      $display("FAIL reset_mid: q=%h q_bar=%h expected q=0 q_bar=F", q, q_bar);
    end
    rst = 1'b0;
`ifdef T_FF_LOAD_EN
    load = 1'b0;
`endif
  endtask

`ifdef T_FF_LOAD_EN
  task automatic test_load();
    en = 1'b0; mode = 1'b1; up = 1'b1; load = 1'b1; d = 4'h9;
    tick();
    checks++;
    if (q !== 4'h9) begin
      failures++;
      $display("FAIL load: q=%h expected 9", q);
    end
    load = 1'b0; en = 1'b1;
    tick();
    checks++;
    if (q !== 4'hA) begin
      failures++;
      $display("FAIL load_then_count: q=%h expected A", q);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; up = 1'b1; t = 4'h0;
`ifdef T_FF_LOAD_EN
    load = 1'b0; d = 4'h0;
`endif
    #1;
    test_reset();
    test_indep();
    test_count_up();
    test_count_down();
    test_reset_mid();
`ifdef T_FF_LOAD_EN
    test_load();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
